// File: rtl/ex_pkg.sv
// Shared definitions for the MIPS execute stage.
// Bundle bit positions, ALU op/funct codes, ALU control, FSM and EX/MEM types.
package ex_pkg;

    localparam int EX_REGDST   = 14;
    localparam int EX_ALUSRC   = 13;
    localparam int EX_ALUOP_HI = 12;
    localparam int EX_ALUOP_LO = 11;
    localparam int EX_SHAMT_HI = 10;
    localparam int EX_SHAMT_LO = 6;
    localparam int EX_FUNCT_HI = 5;
    localparam int EX_FUNCT_LO = 0;

    localparam int WB_REGWRITE = 1;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_FUNCT = 2'b10;
    localparam logic [1:0] OP_OR    = 2'b11;

    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_MULT = 6'h18;
    localparam logic [5:0] F_MFHI = 6'h10;
    localparam logic [5:0] F_MFLO = 6'h12;

    typedef enum logic [3:0] {
        ALU_NOP,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_SLL,
        ALU_SRL,
        ALU_MULT,
        ALU_MFHI,
        ALU_MFLO
    } alu_ctrl_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } mul_state_e;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [4:0]  dst;
        logic [1:0]  m;
        logic [1:0]  wb;
    } exmem_t;

    function automatic alu_ctrl_e alu_decode(
        input logic [1:0] op,
        input logic [5:0] fn
    );
        alu_ctrl_e c;
        c = ALU_NOP;
        case (op)
            OP_ADD: c = ALU_ADD;
            OP_SUB: c = ALU_SUB;
            OP_OR:  c = ALU_OR;
            default: begin
                case (fn)
                    F_ADD:   c = ALU_ADD;
                    F_SUB:   c = ALU_SUB;
                    F_AND:   c = ALU_AND;
                    F_OR:    c = ALU_OR;
                    F_SLT:   c = ALU_SLT;
                    F_SLL:   c = ALU_SLL;
                    F_SRL:   c = ALU_SRL;
                    F_MULT:  c = ALU_MULT;
                    F_MFHI:  c = ALU_MFHI;
                    F_MFLO:  c = ALU_MFLO;
                    default: c = ALU_NOP;
                endcase
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational ALU for the execute stage.
// Ports: a, b operands; shamt shift amount (applied to b); ctrl op; result.
module alu
    import ex_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    input  alu_ctrl_e   ctrl,
    output logic [31:0] result
);

    always_comb begin
        result = '0;
        case (ctrl)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {31'b0, ($signed(a) < $signed(b))};
            ALU_SLL: result = b << shamt;
            ALU_SRL: result = b >> shamt;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: forwarding, ALU, multi-cycle multiplier and EX/MEM reg.
// Ports: ID/EX operands/control in, MEM/WB forward in, stall and exmem_* out.
module ex_stage
    import ex_pkg::*;
#(
    parameter int MULT_LAT = 4
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] data_in,
    input  logic [31:0] imm_in,
    input  logic [14:0] ex_in,
    input  logic [1:0]  m_in,
    input  logic [1:0]  wb_in,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    input  logic [4:0]  rd_addr,
    input  logic        memwb_reg_write,
    input  logic [4:0]  memwb_dst,
    input  logic [31:0] memwb_data,
    output logic        stall,
    output logic [31:0] exmem_alu,
    output logic [31:0] exmem_wdata,
    output logic [4:0]  exmem_dst,
    output logic [1:0]  exmem_m,
    output logic [1:0]  exmem_wb
);

    localparam int CW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MULT_LAT - 1);

    logic [31:0] rs_data, rt_data;
    logic [31:0] fwd_rs, fwd_rt;
    logic [31:0] alu_b, alu_res, result;
    alu_ctrl_e   ctrl;
    logic        is_mult, is_mdu;
    logic        issue, done;

    mul_state_e  state, state_d;
    logic [CW-1:0] cnt;
    logic signed [31:0] op_a, op_b;
    logic signed [63:0] prod;
    logic [31:0] hi, lo;

    exmem_t exmem;

    assign rs_data = data_in[63:32];
    assign rt_data = data_in[31:0];

    assign ctrl = alu_decode(ex_in[EX_ALUOP_HI:EX_ALUOP_LO],
                             ex_in[EX_FUNCT_HI:EX_FUNCT_LO]);

    assign is_mult = (ctrl == ALU_MULT);
    assign is_mdu  = is_mult || (ctrl == ALU_MFHI) || (ctrl == ALU_MFLO);

    // EX/MEM result is newer than MEM/WB, so it is checked first.
    always_comb begin
        fwd_rs = rs_data;
        if (exmem.wb[WB_REGWRITE] && exmem.dst != '0 &&
            exmem.dst == rs_addr)
            fwd_rs = exmem.alu;
        else if (memwb_reg_write && memwb_dst != '0 &&
                 memwb_dst == rs_addr)
            fwd_rs = memwb_data;
    end

    always_comb begin
        fwd_rt = rt_data;
        if (exmem.wb[WB_REGWRITE] && exmem.dst != '0 &&
            exmem.dst == rt_addr)
            fwd_rt = exmem.alu;
        else if (memwb_reg_write && memwb_dst != '0 &&
                 memwb_dst == rt_addr)
            fwd_rt = memwb_data;
    end

    assign alu_b = ex_in[EX_ALUSRC] ? imm_in : fwd_rt;

    alu u_alu (
        .a      (fwd_rs),
        .b      (alu_b),
        .shamt  (ex_in[EX_SHAMT_HI:EX_SHAMT_LO]),
        .ctrl   (ctrl),
        .result (alu_res)
    );

    always_comb begin
        result = alu_res;
        if (ctrl == ALU_MFHI)
            result = hi;
        else if (ctrl == ALU_MFLO)
            result = lo;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (is_mult) state_d = S_BUSY;
            S_BUSY:  if (cnt == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A held mfhi/mflo keeps stalling on the HI/LO write cycle itself.
    always_comb begin
        issue = (state == S_IDLE) && is_mult;
        done  = (state == S_BUSY) && (cnt == '0);
        stall = (state == S_BUSY) && is_mdu;
    end

    assign prod = 64'(op_a) * 64'(op_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            op_a <= '0;
            op_b <= '0;
            hi   <= '0;
            lo   <= '0;
        end else begin
            if (issue) begin
                op_a <= fwd_rs;
                op_b <= fwd_rt;
                cnt  <= CNT_INIT;
            end else if (state == S_BUSY && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (done)
                {hi, lo} <= prod;
        end
    end

    // mult itself never writes a register or memory.
    always_ff @(posedge clk) begin
        if (rst || stall) begin
            exmem <= '0;
        end else begin
            exmem.alu   <= result;
            exmem.wdata <= fwd_rt;
            exmem.dst   <= ex_in[EX_REGDST] ? rd_addr : rt_addr;
            exmem.m     <= is_mult ? 2'b00 : m_in;
            exmem.wb    <= is_mult ? 2'b00 : wb_in;
        end
    end

    assign exmem_alu   = exmem.alu;
    assign exmem_wdata = exmem.wdata;
    assign exmem_dst   = exmem.dst;
    assign exmem_m     = exmem.m;
    assign exmem_wb    = exmem.wb;

endmodule
